ethernet_sys_gpio_ctrl: RTL and testbench
=========================================

Name: ethernet_sys_gpio_ctrl

Overview:
- Parametrised Avalon-MM general-purpose I/O slave. Successor to the fixed 3-bit write-only PIO.
- Adds configurable width, per-bit direction, atomic set/clear, synchronised input readback, edge capture and a maskable level interrupt.
- Sits on the ethernet_sys Avalon-MM fabric and drives board-level LEDs, PHY straps and status pins.

Parameters:
- WIDTH, 8, number of I/O bits, legal range 1..32.
- RESET_VALUE, 0, reset value of data_out (WIDTH bits).
- EDGE_TYPE, 0, edge-capture event: 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2, input synchroniser depth, minimum 2.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 3, word address.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- readdata, output, 32, read data, zero-extended above WIDTH.
- in_port, input, WIDTH, pin inputs, asynchronous to clk.
- out_port, output, WIDTH, data_out register.
- oe, output, WIDTH, per-bit output enable (direction register).
- irq, output, 1, level interrupt.

Behaviour:
- Clocking and reset: single clock clk. reset_n is asynchronous, active-low.
- Reset values: data_out = RESET_VALUE; direction = 0 (all inputs); irq_mask = 0; edge_capture = 0; synchroniser and delay flops = 0; irq = 0.
- Write strobe: wr = chipselect & ~write_n. Only writedata[WIDTH-1:0] is used.
- Address map, write side:
  - 0: data_out <= wd.
  - 1: direction <= wd.
  - 2: irq_mask <= wd.
  - 3: edge_capture <= edge_capture & ~wd (write-1-to-clear).
  - 4: outset, data_out <= data_out | wd.
  - 5: outclear, data_out <= data_out & ~wd.
  - 6, 7: writes ignored.
- Address map, read side (combinational, read latency 0):
  - 0: in_sync.
  - 1: direction.
  - 2: irq_mask.
  - 3: edge_capture.
  - 4: data_out.
  - 5, 6, 7: return 0.
  - Bits [31:WIDTH] always read 0.
- Input path: in_port passes through SYNC_STAGES flops to give in_sync. One further flop gives in_prev.
- Edge event per bit:
  - Rising: in_sync & ~in_prev.
  - Falling: ~in_sync & in_prev.
  - Any: in_sync ^ in_prev.
- Edge detection runs on every bit, whatever its direction.
- Latency: a pin transition is visible at address 0 after SYNC_STAGES clocks. The edge_capture bit sets one clock after that.
- edge_capture bits are sticky until cleared. If an event and a W1C hit the same bit in the same cycle, set wins.
- Outputs: irq = |(edge_capture & irq_mask), registered, so it asserts 1 clock after the capture bit sets. out_port = data_out. oe = direction.
- Register updates: only one register updates per write, since address selects exactly one of data/outset/outclear.
- Reset mid-operation clears all state immediately. A pending edge is lost.
- No wait states and no read side effects.

Decomposition:
- Package ethernet_sys_gpio_pkg:
  - Address constants GPIO_ADDR_DATA=0, GPIO_ADDR_DIR=1, GPIO_ADDR_MASK=2, GPIO_ADDR_EDGE=3, GPIO_ADDR_SET=4, GPIO_ADDR_CLR=5.
  - EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module ethernet_sys_gpio_sync_edge(WIDTH, SYNC_STAGES, EDGE_TYPE):
  - Holds the synchroniser chain, in_prev and the edge-event vector.
  - Exposes in_sync and event.

Test Plan:
- Reset with RESET_VALUE=8'hA5 -> out_port=A5, oe=00, irq=0, readdata at address 4 = 0000_00A5.
- Write 8'h0F to address 0, then 8'h30 to address 4, then 8'h05 to address 5 -> out_port reads 0F, then 3F, then 3A. Address 4 read returns 0000_003A.
- EDGE_TYPE=0, mask=8'h01, drive in_port[0] 0->1 -> address 0 bit0=1 after 2 clocks, edge_capture=01 after 3 clocks, irq=1 after 4 clocks.
- Write 8'h01 to address 3 in the same cycle as a new rising event on bit0 -> edge_capture bit0 stays 1 and irq stays 1. The next clear write with no event -> bit0=0, and irq=0 one clock later.
- WIDTH=32, EDGE_TYPE=2, toggle in_port[31] 1->0 -> edge_capture=8000_0000. The same toggle with mask=0 -> irq stays 0.
- Assert reset_n low mid-sequence with edge_capture=FF and out_port=3A -> all registers and irq return to reset values without a clock edge. Reads of addresses 6 and 7 return 0.

Source files
------------

// File: rtl/ethernet_sys_gpio_pkg.sv
// Shared constants for the ethernet_sys GPIO slave: register word addresses
// and the edge-capture event encodings.
package ethernet_sys_gpio_pkg;

    // Register word addresses on the Avalon-MM slave port
    localparam logic [2:0] GPIO_ADDR_DATA = 3'd0;
    localparam logic [2:0] GPIO_ADDR_DIR  = 3'd1;
    localparam logic [2:0] GPIO_ADDR_MASK = 3'd2;
    localparam logic [2:0] GPIO_ADDR_EDGE = 3'd3;
    localparam logic [2:0] GPIO_ADDR_SET  = 3'd4;
    localparam logic [2:0] GPIO_ADDR_CLR  = 3'd5;

    // Edge-capture event selection
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/ethernet_sys_gpio_sync_edge.sv
// Input path for the GPIO slave: a SYNC_STAGES-deep synchroniser for the
// asynchronous pins, one delay flop and the per-bit edge-event vector.
module ethernet_sys_gpio_sync_edge
    import ethernet_sys_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] in_sync,
    output logic [WIDTH-1:0] edge_event
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] in_prev;

    // Shift the pins through the synchroniser and keep one delayed copy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sync_q is a handful of flops, not a RAM, so resetting every entry is cheap and keeps in_sync clean out of reset.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            in_prev <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value, which is what builds the shift chain.
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            in_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_sync = sync_q[SYNC_STAGES-1];

    // Compare the synchronised value with its delayed copy to form the event
    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_event = ~in_sync & in_prev;
            EDGE_ANY:  edge_event = in_sync ^ in_prev;
            default:   edge_event = in_sync & ~in_prev;
        endcase
    end

endmodule

// File: rtl/ethernet_sys_gpio_ctrl.sv
// Parametrised Avalon-MM GPIO slave: data/direction registers with atomic
// set/clear, synchronised pin readback, sticky edge capture and a maskable
// registered level interrupt. Zero wait states, no read side effects.
module ethernet_sys_gpio_ctrl
    import ethernet_sys_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_event;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] direction;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rd_val;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];

    // Bits above WIDTH are accepted on the bus but carry no state
    if (WIDTH < 32) begin : g_wd_hi
        logic unused_wd_hi;
        assign unused_wd_hi = ^writedata[31:WIDTH];
    end

    ethernet_sys_gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_port    (in_port),
        .in_sync    (in_sync),
        .edge_event (edge_event)
    );

    // Output data, direction and mask registers; address picks exactly one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out  <= RESET_VALUE;
            direction <= '0;
            irq_mask  <= '0;
        end else if (wr) begin
            case (address)
                GPIO_ADDR_DATA: data_out  <= wd;
                GPIO_ADDR_DIR:  direction <= wd;
                GPIO_ADDR_MASK: irq_mask  <= wd;
                GPIO_ADDR_SET:  data_out  <= data_out | wd;
                GPIO_ADDR_CLR:  data_out  <= data_out & ~wd;
                default: ;
            endcase
        end
    end

    assign edge_clr = (wr && address == GPIO_ADDR_EDGE) ? wd : '0;

    // Sticky edge capture (W1C, a same-cycle event wins) and registered irq
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture <= '0;
            irq          <= 1'b0;
        end else begin
            edge_capture <= (edge_capture & ~edge_clr) | edge_event;
            irq          <= |(edge_capture & irq_mask);
        end
    end

    // Zero-latency read mux, zero-extended to the 32-bit bus
    always_comb begin
        // NOTE: defaults first so every path assigns rd_val and readdata; no latch is inferred for unmapped addresses.
        rd_val   = '0;
        readdata = '0;
        case (address)
            GPIO_ADDR_DATA: rd_val = in_sync;
            GPIO_ADDR_DIR:  rd_val = direction;
            GPIO_ADDR_MASK: rd_val = irq_mask;
            GPIO_ADDR_EDGE: rd_val = edge_capture;
            GPIO_ADDR_SET:  rd_val = data_out;
            default:        rd_val = '0;
        endcase
        readdata[WIDTH-1:0] = rd_val;
    end

    assign out_port = data_out;
    assign oe       = direction;

endmodule

// File: tb/tb_ethernet_sys_gpio_ctrl.sv
// Bench for ethernet_sys_gpio_ctrl: an 8-bit rising-edge instance (A) and a
// 32-bit any-edge instance (B). Read expectations go through a scoreboard
// queue: pushed when the read is issued, popped and compared on the data.
module tb_ethernet_sys_gpio_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [2:0]  a_address, b_address;
    logic        a_cs, b_cs, a_wn, b_wn;
    logic [31:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic [7:0]  a_in, a_out, a_oe;
    logic [31:0] b_in, b_out, b_oe;
    logic        a_irq, b_irq;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] rd;
    int          errors = 0;
    int          checks = 0;

    ethernet_sys_gpio_ctrl #(
        .WIDTH (8), .RESET_VALUE (8'hA5), .EDGE_TYPE (0), .SYNC_STAGES (2)
    ) dut_a (
        .clk (clk), .reset_n (reset_n), .address (a_address), .chipselect (a_cs),
        .write_n (a_wn), .writedata (a_wdata), .readdata (a_rdata),
        .in_port (a_in), .out_port (a_out), .oe (a_oe), .irq (a_irq)
    );

    ethernet_sys_gpio_ctrl #(
        .WIDTH (32), .RESET_VALUE (32'h0), .EDGE_TYPE (2), .SYNC_STAGES (2)
    ) dut_b (
        .clk (clk), .reset_n (reset_n), .address (b_address), .chipselect (b_cs),
        .write_n (b_wn), .writedata (b_wdata), .readdata (b_rdata),
        .in_port (b_in), .out_port (b_out), .oe (b_oe), .irq (b_irq)
    );

    // One-cycle Avalon write, driven between falling edges
    task automatic bus_write(input bit sel_b, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        if (sel_b) begin
            b_address = a; b_cs = 1'b1; b_wn = 1'b0; b_wdata = d;
        end else begin
            a_address = a; a_cs = 1'b1; a_wn = 1'b0; a_wdata = d;
        end
        @(negedge clk);
        a_cs = 1'b0; a_wn = 1'b1; b_cs = 1'b0; b_wn = 1'b1;
    endtask

    // Combinational read: set the address and sample readdata 1 time unit later
    task automatic peek(input bit sel_b, input logic [2:0] a, output logic [31:0] d);
        if (sel_b) begin
            b_address = a; #1 d = b_rdata;
        end else begin
            a_address = a; #1 d = a_rdata;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_address = '0; a_cs = 1'b0; a_wn = 1'b1; a_wdata = '0; a_in = '0;
        b_address = '0; b_cs = 1'b0; b_wn = 1'b1; b_wdata = '0; b_in = '0;
        #12;
        checks++; if (a_out !== 8'hA5) begin errors++; $display("FAIL rst_out_a: got %h expected a5", a_out); end
        checks++; if (a_oe !== 8'h00) begin errors++; $display("FAIL rst_oe_a: got %h expected 00", a_oe); end
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL rst_irq_a: got %b expected 0", a_irq); end
        checks++; if (b_out !== 32'h0) begin errors++; $display("FAIL rst_out_b: got %h expected 0", b_out); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        sb.push_back('{name: "rst_rd4_a", exp: 32'h0000_00A5});
        peek(0, 3'd4, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
    endtask

    task automatic test_data_regs();
        bus_write(0, 3'd0, 32'h0000_000F);
        checks++; if (a_out !== 8'h0F) begin errors++; $display("FAIL data_wr: got %h expected 0f", a_out); end
        bus_write(0, 3'd4, 32'h0000_0030);
        checks++; if (a_out !== 8'h3F) begin errors++; $display("FAIL outset: got %h expected 3f", a_out); end
        bus_write(0, 3'd5, 32'h0000_0005);
        checks++; if (a_out !== 8'h3A) begin errors++; $display("FAIL outclear: got %h expected 3a", a_out); end
        sb.push_back('{name: "rd_data_out", exp: 32'h0000_003A});
        peek(0, 3'd4, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        bus_write(0, 3'd1, 32'hFFFF_FFC3);
        checks++; if (a_oe !== 8'hC3) begin errors++; $display("FAIL dir_oe: got %h expected c3", a_oe); end
        sb.push_back('{name: "rd_dir", exp: 32'h0000_00C3});
        peek(0, 3'd1, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        bus_write(0, 3'd2, 32'hFFFF_FF00);
        sb.push_back('{name: "rd_mask_hi_ignored", exp: 32'h0});
        peek(0, 3'd2, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        bus_write(0, 3'd6, 32'hFFFF_FFFF);
        bus_write(0, 3'd7, 32'h0000_0000);
        checks++; if ({a_out, a_oe} !== 16'h3AC3) begin errors++; $display("FAIL wr67_ignored: got %h expected 3ac3", {a_out, a_oe}); end
        for (int i = 5; i < 8; i++) begin
            sb.push_back('{name: $sformatf("rd_unmapped_%0d", i), exp: 32'h0});
            peek(0, 3'(i), rd); e = sb.pop_front();
            checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        end
    endtask

    task automatic test_edge_irq();
        bus_write(0, 3'd2, 32'h0000_0001);
        @(negedge clk);
        a_in[0] = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{name: "sync_1clk", exp: 32'h0});
        peek(0, 3'd0, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        @(posedge clk); #1;
        sb.push_back('{name: "sync_2clk", exp: 32'h1});
        sb.push_back('{name: "edge_2clk", exp: 32'h0});
        peek(0, 3'd0, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        peek(0, 3'd3, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        @(posedge clk); #1;
        sb.push_back('{name: "edge_3clk", exp: 32'h1});
        peek(0, 3'd3, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL irq_3clk: got %b expected 0", a_irq); end
        @(posedge clk); #1;
        checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL irq_4clk: got %b expected 1", a_irq); end
    endtask

    task automatic test_w1c_collision();
        @(negedge clk);
        a_in[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        a_address = 3'd3; a_cs = 1'b1; a_wn = 1'b0; a_wdata = 32'h1;
        @(posedge clk); #1;
        a_cs = 1'b0; a_wn = 1'b1;
        sb.push_back('{name: "w1c_set_wins", exp: 32'h1});
        peek(0, 3'd3, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        @(posedge clk); #1;
        checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_held: got %b expected 1", a_irq); end
        bus_write(0, 3'd3, 32'h1);
        sb.push_back('{name: "w1c_clear", exp: 32'h0});
        peek(0, 3'd3, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_lag: got %b expected 1", a_irq); end
        @(posedge clk); #1;
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_drop: got %b expected 0", a_irq); end
    endtask

    task automatic test_wide_any_edge();
        @(negedge clk);
        b_in[31] = 1'b1;
        repeat (4) @(posedge clk);
        bus_write(1, 3'd3, 32'hFFFF_FFFF);
        sb.push_back('{name: "b_edge_cleared", exp: 32'h0});
        sb.push_back('{name: "b_sync_hi", exp: 32'h8000_0000});
        peek(1, 3'd3, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        peek(1, 3'd0, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        @(negedge clk);
        b_in[31] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        sb.push_back('{name: "b_fall_2clk", exp: 32'h0});
        peek(1, 3'd3, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        @(posedge clk); #1;
        sb.push_back('{name: "b_fall_3clk", exp: 32'h8000_0000});
        peek(1, 3'd3, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        repeat (2) @(posedge clk); #1;
        checks++; if (b_irq !== 1'b0) begin errors++; $display("FAIL b_irq_masked: got %b expected 0", b_irq); end
        bus_write(1, 3'd2, 32'h8000_0000);
        checks++; if (b_irq !== 1'b0) begin errors++; $display("FAIL b_irq_lag: got %b expected 0", b_irq); end
        @(posedge clk); #1;
        checks++; if (b_irq !== 1'b1) begin errors++; $display("FAIL b_irq_unmasked: got %b expected 1", b_irq); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a_in = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        a_in = 8'hFF;
        repeat (4) @(posedge clk); #1;
        sb.push_back('{name: "pre_rst_edge", exp: 32'h0000_00FF});
        peek(0, 3'd3, rd); e = sb.pop_front();
        checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        checks++; if ({a_out, a_irq} !== 9'h075) begin errors++; $display("FAIL pre_rst_state: got %h expected 075", {a_out, a_irq}); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (a_out !== 8'hA5) begin errors++; $display("FAIL mid_rst_out: got %h expected a5", a_out); end
        checks++; if (a_oe !== 8'h00) begin errors++; $display("FAIL mid_rst_oe: got %h expected 00", a_oe); end
        checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got %b expected 0", a_irq); end
        checks++; if ({b_out, b_irq} !== 33'h0) begin errors++; $display("FAIL mid_rst_b: got %h expected 0", {b_out, b_irq}); end
        sb.push_back('{name: "mid_rst_rd0", exp: 32'h0});
        sb.push_back('{name: "mid_rst_rd1", exp: 32'h0});
        sb.push_back('{name: "mid_rst_rd2", exp: 32'h0});
        sb.push_back('{name: "mid_rst_rd3", exp: 32'h0});
        sb.push_back('{name: "mid_rst_rd4", exp: 32'h0000_00A5});
        sb.push_back('{name: "mid_rst_rd5", exp: 32'h0});
        sb.push_back('{name: "mid_rst_rd6", exp: 32'h0});
        sb.push_back('{name: "mid_rst_rd7", exp: 32'h0});
        for (int i = 0; i < 8; i++) begin
            peek(0, 3'(i), rd); e = sb.pop_front();
            checks++; if (rd !== e.exp) begin errors++; $display("FAIL %s: got %h expected %h", e.name, rd, e.exp); end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_data_regs();
        test_edge_irq();
        test_w1c_collision();
        test_wide_any_edge();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
